// File: rtl/llm_dat_flit_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : llm_dat_flit_tx_if
//  Description : Segment-input and DAT-flit-output bundle of llm_dat_flit_tx.
//                The master view belongs to the flit transmitter; the slave
//                view belongs to the splitter and link partner around it.
//  Revision    : 1.0  initial release
// ============================================================================
interface llm_dat_flit_tx_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TXNID_WIDTH = 12
);
    logic [DATA_WIDTH-1:0]   seg_data;
    logic [DATA_WIDTH/8-1:0] seg_be;
    logic [TXNID_WIDTH-1:0]  seg_txnid;
    logic                    seg_last;
    logic                    seg_valid;
    logic                    seg_ready;

    logic                    txdat_flitpend;
    logic                    txdat_flitv;
    logic [DATA_WIDTH-1:0]   dat_data;
    logic [DATA_WIDTH/8-1:0] dat_be;
    logic [TXNID_WIDTH-1:0]  dat_txnid;
    logic [1:0]              dat_dataid;
    logic [DATA_WIDTH/8-1:0] dat_datacheck;
    logic                    txdat_lcrdv;

    logic [3:0]              crd_cnt;
    logic                    err_seq;

    modport master (
        input  seg_data, seg_be, seg_txnid, seg_last, seg_valid, txdat_lcrdv,
        output seg_ready, txdat_flitpend, txdat_flitv, dat_data, dat_be,
               dat_txnid, dat_dataid, dat_datacheck, crd_cnt, err_seq
    );

    modport slave (
        output seg_data, seg_be, seg_txnid, seg_last, seg_valid, txdat_lcrdv,
        input  seg_ready, txdat_flitpend, txdat_flitv, dat_data, dat_be,
               dat_txnid, dat_dataid, dat_datacheck, crd_cnt, err_seq
    );
endinterface
`default_nettype wire

// File: rtl/llm_dat_flit_tx.sv
`default_nettype none
// ============================================================================
//  Module      : llm_dat_flit_tx
//  Description : CHI DAT transmit stage: buffers split data beats, tags them
//                with TxnID/DataID and launches flits under link credits.
//                Optional macro LLM_DAT_DATACHECK_EN adds per-byte odd parity.
//  Revision    : 1.0  initial release
// ============================================================================
module llm_dat_flit_tx #(
    parameter int DATA_WIDTH  = 256,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_CREDITS = 15,
    parameter int TXNID_WIDTH = 12
) (
    input  logic                clk,
    input  logic                rst,
    llm_dat_flit_tx_if.master   bus
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_full    = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       c_max_crd = 4'(MAX_CREDITS);

    // Beat buffer storage; contents are only meaningful under r_count
    logic [DATA_WIDTH-1:0]  r_mem_data   [FIFO_DEPTH];
    logic [BE_W-1:0]        r_mem_be     [FIFO_DEPTH];
    logic [TXNID_WIDTH-1:0] r_mem_txnid  [FIFO_DEPTH];
    logic [1:0]             r_mem_dataid [FIFO_DEPTH];

    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_nxt;

    logic                   r_beat_idx;
    logic                   r_err_seq;
    logic [3:0]             r_crd;
    logic [3:0]             w_crd_nxt;

    logic                   r_flitpend;
    logic                   r_flitv;
    logic [DATA_WIDTH-1:0]  r_dat_data;
    logic [BE_W-1:0]        r_dat_be;
    logic [TXNID_WIDTH-1:0] r_dat_txnid;
    logic [1:0]             r_dat_dataid;

    logic                   w_ready;
    logic                   w_push;
    logic                   w_launch;

    // Ready comes from the registered count only, so a pop never frees a slot
    // in the same cycle it happens.
    assign w_ready  = (r_count != c_full);
    assign w_push   = bus.seg_valid && w_ready;
    assign w_launch = (r_count != '0) && (r_crd != 4'd0) && r_flitpend;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_launch})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_crd_nxt = r_crd;
        if (bus.txdat_lcrdv && !w_launch) begin
            if (r_crd != c_max_crd) begin
                w_crd_nxt = r_crd + 4'd1;
            end
        end else if (!bus.txdat_lcrdv && w_launch) begin
            w_crd_nxt = r_crd - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr]   <= bus.seg_data;
            r_mem_be[r_wr_ptr]     <= bus.seg_be;
            r_mem_txnid[r_wr_ptr]  <= bus.seg_txnid;
            r_mem_dataid[r_wr_ptr] <= {r_beat_idx, 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_crd      <= 4'd0;
            r_flitpend <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_launch) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_nxt;
            r_crd      <= w_crd_nxt;
            r_flitpend <= (w_count_nxt != '0);
        end
    end

    // A beat without seg_last after a second beat is a splitter fault; the
    // index wraps so the next transaction still starts at DataID 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_idx <= 1'b0;
            r_err_seq  <= 1'b0;
        end else if (w_push) begin
            if (bus.seg_last) begin
                r_beat_idx <= 1'b0;
            end else if (r_beat_idx) begin
                r_beat_idx <= 1'b0;
                r_err_seq  <= 1'b1;
            end else begin
                r_beat_idx <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flitv      <= 1'b0;
            r_dat_data   <= '0;
            r_dat_be     <= '0;
            r_dat_txnid  <= '0;
            r_dat_dataid <= 2'd0;
        end else begin
            r_flitv <= w_launch;
            if (w_launch) begin
                r_dat_data   <= r_mem_data[r_rd_ptr];
                r_dat_be     <= r_mem_be[r_rd_ptr];
                r_dat_txnid  <= r_mem_txnid[r_rd_ptr];
                r_dat_dataid <= r_mem_dataid[r_rd_ptr];
            end
        end
    end

`ifdef LLM_DAT_DATACHECK_EN
    logic [BE_W-1:0] w_rd_parity;
    logic [BE_W-1:0] r_dat_datacheck;

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_parity
        assign w_rd_parity[gi] = ~^r_mem_data[r_rd_ptr][8*gi +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dat_datacheck <= '0;
        end else if (w_launch) begin
            r_dat_datacheck <= w_rd_parity;
        end
    end

    assign bus.dat_datacheck = r_dat_datacheck;
`else
    assign bus.dat_datacheck = '0;
`endif

    assign bus.seg_ready      = w_ready;
    assign bus.txdat_flitpend = r_flitpend;
    assign bus.txdat_flitv    = r_flitv;
    assign bus.dat_data       = r_dat_data;
    assign bus.dat_be         = r_dat_be;
    assign bus.dat_txnid      = r_dat_txnid;
    assign bus.dat_dataid     = r_dat_dataid;
    assign bus.crd_cnt        = r_crd;
    assign bus.err_seq        = r_err_seq;

    a_pend_before_flitv : assert property (
        @(posedge clk) disable iff (rst) r_flitv |-> $past(r_flitpend));

    a_crd_bounded : assert property (
        @(posedge clk) disable iff (rst) r_crd <= c_max_crd);

endmodule
`default_nettype wire

// File: tb/tb_llm_dat_flit_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_llm_dat_flit_tx
//  Description : Directed self-checking bench for llm_dat_flit_tx.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_llm_dat_flit_tx;

    localparam int DW   = 256;
    localparam int BW   = DW / 8;
    localparam int TW   = 12;
    localparam int DEPTH = 4;
    localparam int MAXC = 15;

`ifdef LLM_DAT_DATACHECK_EN
    localparam logic [31:0] c_chk_a = 32'hFFFF_FFFE;
    localparam logic [31:0] c_chk_b = 32'hFFFF_FFF7;
`else
    localparam logic [31:0] c_chk_a = 32'h0000_0000;
    localparam logic [31:0] c_chk_b = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    llm_dat_flit_tx_if #(.DATA_WIDTH(DW), .TXNID_WIDTH(TW)) bus ();

    llm_dat_flit_tx #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .MAX_CREDITS(MAXC),
        .TXNID_WIDTH(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flit monitor: captures each flit and the flitpend seen the cycle before
    logic        prev_pend;
    logic [63:0] f_data   [$];
    logic [TW-1:0] f_txnid [$];
    logic [1:0]  f_dataid [$];
    logic [31:0] f_chk    [$];
    int          f_cyc    [$];

    always @(negedge clk) begin
        if (rst) begin
            prev_pend = 1'b0;
        end else begin
            if (bus.txdat_flitv) begin
                chk("pend_before_flitv", 64'(prev_pend), 64'd1);
                f_data.push_back(bus.dat_data[63:0]);
                f_txnid.push_back(bus.dat_txnid);
                f_dataid.push_back(bus.dat_dataid);
                f_chk.push_back(bus.dat_datacheck[31:0]);
                f_cyc.push_back(cyc);
            end
            prev_pend = bus.txdat_flitpend;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        f_data.delete();
        f_txnid.delete();
        f_dataid.delete();
        f_chk.delete();
        f_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.seg_valid   = 1'b0;
        bus.seg_last    = 1'b0;
        bus.txdat_lcrdv = 1'b0;
        tick(2);
        clear_q();
        rst = 1'b0;
        tick(1);
    endtask

    task automatic credits(input int n);
        bus.txdat_lcrdv = 1'b1;
        tick(n);
        bus.txdat_lcrdv = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [TW-1:0] id,
                        input logic last, output int acc_cyc);
        bus.seg_data  = d;
        bus.seg_be    = '1;
        bus.seg_txnid = id;
        bus.seg_last  = last;
        bus.seg_valid = 1'b1;
        acc_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            if (bus.seg_ready) begin
                acc_cyc = cyc;
                tick(1);
                break;
            end
            tick(1);
        end
        bus.seg_valid = 1'b0;
        if (acc_cyc < 0) chk("push_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int a0, a1, dummy;
        bus.seg_data = '0; bus.seg_be = '0; bus.seg_txnid = '0;
        bus.seg_last = 1'b0; bus.seg_valid = 1'b0; bus.txdat_lcrdv = 1'b0;
        rst = 1'b1;
        tick(2);
        chk("rst_seg_ready", 64'(bus.seg_ready), 64'd1);
        chk("rst_flitpend",  64'(bus.txdat_flitpend), 64'd0);
        chk("rst_flitv",     64'(bus.txdat_flitv), 64'd0);
        chk("rst_crd",       64'(bus.crd_cnt), 64'd0);
        chk("rst_err",       64'(bus.err_seq), 64'd0);
        chk("rst_dat_data",  bus.dat_data[63:0], 64'd0);
        chk("rst_datacheck", 64'(bus.dat_datacheck[31:0]), 64'd0);
        rst = 1'b0;
        tick(1);

        // Two-beat transaction with four credits
        credits(4);
        chk("t1_crd_after_return", 64'(bus.crd_cnt), 64'd4);
        push(256'h0301, 12'h05A, 1'b0, a0);
        chk("t1_pend_after_accept", 64'(bus.txdat_flitpend), 64'd1);
        push(256'hAB00_0003, 12'h05A, 1'b1, a1);
        tick(4);
        chk("t1_nflits", 64'(f_data.size()), 64'd2);
        if (f_data.size() == 2) begin
            chk("t1_dataid0", 64'(f_dataid[0]), 64'd0);
            chk("t1_dataid1", 64'(f_dataid[1]), 64'd2);
            chk("t1_txnid0",  64'(f_txnid[0]), 64'h05A);
            chk("t1_txnid1",  64'(f_txnid[1]), 64'h05A);
            chk("t1_data0",   f_data[0], 64'h0301);
            chk("t1_data1",   f_data[1], 64'hAB00_0003);
            chk("t1_chk0",    64'(f_chk[0]), 64'(c_chk_a));
            chk("t1_chk1",    64'(f_chk[1]), 64'(c_chk_b));
            chk("t1_latency", 64'(f_cyc[0] - a0), 64'd2);
            chk("t1_b2b",     64'(f_cyc[1] - f_cyc[0]), 64'd1);
        end
        chk("t1_crd_end", 64'(bus.crd_cnt), 64'd2);
        chk("t1_flitv_idle", 64'(bus.txdat_flitv), 64'd0);

        // No credits: FIFO fills, then one credit releases one flit
        do_reset();
        push(256'h11, 12'h101, 1'b0, dummy);
        push(256'h22, 12'h102, 1'b1, dummy);
        push(256'h33, 12'h103, 1'b0, dummy);
        push(256'h44, 12'h104, 1'b1, dummy);
        chk("t2_ready_full", 64'(bus.seg_ready), 64'd0);
        chk("t2_pend_full",  64'(bus.txdat_flitpend), 64'd1);
        bus.seg_data = 256'h55; bus.seg_txnid = 12'h105;
        bus.seg_last = 1'b0;    bus.seg_valid = 1'b1;
        tick(3);
        chk("t2_no_flit", 64'(f_data.size()), 64'd0);
        chk("t2_ready_blocked", 64'(bus.seg_ready), 64'd0);
        credits(1);
        chk("t2_crd_one", 64'(bus.crd_cnt), 64'd1);
        tick(1);
        chk("t2_flitv", 64'(bus.txdat_flitv), 64'd1);
        chk("t2_ready_after_pop", 64'(bus.seg_ready), 64'd1);
        chk("t2_crd_zero", 64'(bus.crd_cnt), 64'd0);
        tick(1);
        bus.seg_valid = 1'b0;
        chk("t2_ready_refull", 64'(bus.seg_ready), 64'd0);
        tick(5);
        chk("t2_nflits", 64'(f_data.size()), 64'd1);
        if (f_data.size() == 1) begin
            chk("t2_txnid", 64'(f_txnid[0]), 64'h101);
            chk("t2_dataid", 64'(f_dataid[0]), 64'd0);
        end

        // Credit saturation, then lcrdv coincident with launch at max
        do_reset();
        bus.txdat_lcrdv = 1'b1;
        tick(20);
        chk("t3_crd_sat", 64'(bus.crd_cnt), 64'd15);
        push(256'h7777, 12'h7FF, 1'b1, dummy);
        tick(3);
        chk("t3_nflits", 64'(f_data.size()), 64'd1);
        chk("t3_crd_hold", 64'(bus.crd_cnt), 64'd15);
        bus.txdat_lcrdv = 1'b0;
        tick(1);
        chk("t3_crd_final", 64'(bus.crd_cnt), 64'd15);

        // Three beats without seg_last until the third
        do_reset();
        credits(4);
        push(256'hA1, 12'h200, 1'b0, dummy);
        chk("t4_err_first", 64'(bus.err_seq), 64'd0);
        push(256'hA2, 12'h200, 1'b0, dummy);
        push(256'hA3, 12'h200, 1'b1, dummy);
        chk("t4_err_set", 64'(bus.err_seq), 64'd1);
        tick(5);
        chk("t4_nflits", 64'(f_data.size()), 64'd3);
        if (f_data.size() == 3) begin
            chk("t4_dataid0", 64'(f_dataid[0]), 64'd0);
            chk("t4_dataid1", 64'(f_dataid[1]), 64'd2);
            chk("t4_dataid2", 64'(f_dataid[2]), 64'd0);
            chk("t4_data2",   f_data[2], 64'hA3);
        end
        chk("t4_crd", 64'(bus.crd_cnt), 64'd1);
        chk("t4_err_sticky", 64'(bus.err_seq), 64'd1);

        // Asynchronous reset with beats queued and a flit on the wire
        do_reset();
        push(256'hB1, 12'h300, 1'b0, dummy);
        push(256'hB2, 12'h300, 1'b1, dummy);
        push(256'hB3, 12'h301, 1'b0, dummy);
        push(256'hB4, 12'h301, 1'b0, dummy);
        credits(1);
        tick(1);
        chk("t6_flitv_pre", 64'(bus.txdat_flitv), 64'd1);
        chk("t6_err_pre", 64'(bus.err_seq), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_flitv_async", 64'(bus.txdat_flitv), 64'd0);
        chk("t6_pend_async",  64'(bus.txdat_flitpend), 64'd0);
        chk("t6_data_async",  bus.dat_data[63:0], 64'd0);
        chk("t6_txnid_async", 64'(bus.dat_txnid), 64'd0);
        chk("t6_err_async",   64'(bus.err_seq), 64'd0);
        chk("t6_crd_async",   64'(bus.crd_cnt), 64'd0);
        tick(1);
        rst = 1'b0;
        clear_q();
        tick(1);
        chk("t6_ready_release", 64'(bus.seg_ready), 64'd1);
        chk("t6_crd_release",   64'(bus.crd_cnt), 64'd0);
        credits(2);
        tick(3);
        chk("t6_no_stale_flit", 64'(f_data.size()), 64'd0);
        chk("t6_crd_kept", 64'(bus.crd_cnt), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
